// File: rtl/dual_block_ram.sv
// dual_block_ram -- true dual-port block RAM with per-byte write enables.
//
// Two independent read/write ports (A: fetch/DMA, B: load/store) share one
// clock. Each port has its own write mode (read-first, write-first,
// no-change) and an optional output register stage shared by both ports.
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous active-high reset (outputs/pipeline only)
//   a_en / b_en            port access enable
//   a_we / b_we            per-byte write enable, ignored while en=0
//   a_addr / b_addr        word address
//   a_wdata / b_wdata      write data
//   a_rdata / b_rdata      read data
//   a_rvalid / b_rvalid    rdata holds the result of an access
//   collision              registered: same address on both ports with a write
//   perr                   registered parity error {B,A}
//
// Build macros
//   BOA_BRAM_PARITY_EN     store one even-parity bit per byte lane and flag
//                          mismatches on read; otherwise perr is 2'b00.
//   BOA_BRAM_SIM           simulation model extras: zero-fill, init_file
//                          loading and a trace line for every committed write.
//                          Without it the contents after configuration are
//                          undefined and init_file is not used.
module dual_block_ram #(
    parameter int    abits     = 8,
    parameter int    dbytes    = 4,
    parameter int    blen      = 8,
    parameter int    a_mode    = 0,
    parameter int    b_mode    = 0,
    parameter int    out_reg   = 0,
    parameter string init_file = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic [dbytes-1:0]       a_we,
    input  logic [abits-1:0]        a_addr,
    input  logic [dbytes*blen-1:0]  a_wdata,
    output logic [dbytes*blen-1:0]  a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [dbytes-1:0]       b_we,
    input  logic [abits-1:0]        b_addr,
    input  logic [dbytes*blen-1:0]  b_wdata,
    output logic [dbytes*blen-1:0]  b_rdata,
    output logic                    b_rvalid,
    output logic                    collision,
    output logic [1:0]              perr
);

    localparam int dbits   = dbytes * blen;
    localparam int depth   = 1 << abits;
    localparam int MODE_WF = 1;
    localparam int MODE_NC = 2;

    logic [dbits-1:0] mem [depth];

    function automatic logic [dbits-1:0] lane_merge(input logic [dbits-1:0] old,
                                                    input logic [dbits-1:0] wd,
                                                    input logic [dbytes-1:0] we);
        logic [dbits-1:0] w;
        w = old;
        for (int i = 0; i < dbytes; i++)
            if (we[i]) w[i*blen +: blen] = wd[i*blen +: blen];
        return w;
    endfunction

    logic [dbits-1:0] a_old, b_old, a_rd_next, b_rd_next;
    logic             a_wr, b_wr, a_hold, b_hold;

    // Cross-port reads always see the pre-edge contents because the array
    // is only updated by non-blocking writes below.
    always_comb begin
        a_old     = mem[a_addr];
        b_old     = mem[b_addr];
        a_wr      = a_en && (a_we != '0);
        b_wr      = b_en && (b_we != '0);
        a_rd_next = (a_mode == MODE_WF) ? lane_merge(a_old, a_wdata, a_we) : a_old;
        b_rd_next = (b_mode == MODE_WF) ? lane_merge(b_old, b_wdata, b_we) : b_old;
        a_hold    = a_wr && (a_mode == MODE_NC);
        b_hold    = b_wr && (b_mode == MODE_NC);
    end

    // Port B is written first so that port A wins a same-lane conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (b_en)
                for (int i = 0; i < dbytes; i++)
                    if (b_we[i]) mem[b_addr][i*blen +: blen] <= b_wdata[i*blen +: blen];
            if (a_en)
                for (int i = 0; i < dbytes; i++)
                    if (a_we[i]) mem[a_addr][i*blen +: blen] <= a_wdata[i*blen +: blen];
        end
    end

`ifdef BOA_BRAM_PARITY_EN
    logic [dbytes-1:0] par [depth];
    logic [dbytes-1:0] a_fwd, b_fwd;
    logic              a_bad, b_bad;
    logic [1:0]        perr_p0;

    function automatic logic [dbytes-1:0] lane_parity(input logic [dbits-1:0] w);
        logic [dbytes-1:0] p;
        for (int i = 0; i < dbytes; i++) p[i] = ^w[i*blen +: blen];
        return p;
    endfunction

    // Lanes forwarded from wdata in write-first mode never touched storage.
    always_comb begin
        a_fwd = (a_mode == MODE_WF) ? a_we : '0;
        b_fwd = (b_mode == MODE_WF) ? b_we : '0;
        a_bad = |((lane_parity(a_old) ^ par[a_addr]) & ~a_fwd);
        b_bad = |((lane_parity(b_old) ^ par[b_addr]) & ~b_fwd);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (b_en)
                for (int i = 0; i < dbytes; i++)
                    if (b_we[i]) par[b_addr][i] <= ^b_wdata[i*blen +: blen];
            if (a_en)
                for (int i = 0; i < dbytes; i++)
                    if (a_we[i]) par[a_addr][i] <= ^a_wdata[i*blen +: blen];
        end
    end

    // Stage p0: parity flag follows the port's rvalid, including no-change holds
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_p0 <= 2'b00;
        end else begin
            if (a_en && !a_hold) perr_p0[0] <= a_bad;
            else if (!a_en)      perr_p0[0] <= 1'b0;
            if (b_en && !b_hold) perr_p0[1] <= b_bad;
            else if (!b_en)      perr_p0[1] <= 1'b0;
        end
    end
`endif

    logic [dbits-1:0] a_rdata_p0, b_rdata_p0;
    logic             a_vld_p0, b_vld_p0;

    // Stage p0: array read; no-change writes keep data and valid as they were
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_p0 <= '0;
            b_rdata_p0 <= '0;
            a_vld_p0   <= 1'b0;
            b_vld_p0   <= 1'b0;
            collision  <= 1'b0;
        end else begin
            if (a_en && !a_hold) begin
                a_rdata_p0 <= a_rd_next;
                a_vld_p0   <= 1'b1;
            end else if (!a_en) begin
                a_vld_p0   <= 1'b0;
            end
            if (b_en && !b_hold) begin
                b_rdata_p0 <= b_rd_next;
                b_vld_p0   <= 1'b1;
            end else if (!b_en) begin
                b_vld_p0   <= 1'b0;
            end
            collision <= a_en && b_en && (a_addr == b_addr) && (a_wr || b_wr);
        end
    end

    // Stage p1: optional output register, data and valid move together
    if (out_reg != 0) begin : g_out_reg
        logic [dbits-1:0] a_rdata_p1, b_rdata_p1;
        logic             a_vld_p1, b_vld_p1;
        always_ff @(posedge clk) begin
            if (rst) begin
                a_rdata_p1 <= '0;
                b_rdata_p1 <= '0;
                a_vld_p1   <= 1'b0;
                b_vld_p1   <= 1'b0;
            end else begin
                a_rdata_p1 <= a_rdata_p0;
                b_rdata_p1 <= b_rdata_p0;
                a_vld_p1   <= a_vld_p0;
                b_vld_p1   <= b_vld_p0;
            end
        end
        assign a_rdata  = a_rdata_p1;
        assign b_rdata  = b_rdata_p1;
        assign a_rvalid = a_vld_p1;
        assign b_rvalid = b_vld_p1;
`ifdef BOA_BRAM_PARITY_EN
        logic [1:0] perr_p1;
        always_ff @(posedge clk) begin
            if (rst) perr_p1 <= 2'b00;
            else     perr_p1 <= perr_p0;
        end
        assign perr = perr_p1;
`endif
    end else begin : g_direct
        assign a_rdata  = a_rdata_p0;
        assign b_rdata  = b_rdata_p0;
        assign a_rvalid = a_vld_p0;
        assign b_rvalid = b_vld_p0;
`ifdef BOA_BRAM_PARITY_EN
        assign perr = perr_p0;
`endif
    end

`ifndef BOA_BRAM_PARITY_EN
    assign perr = 2'b00;
`endif

`ifdef BOA_BRAM_SIM
    initial begin : init_load
        int               c, idx;
        logic [dbits-1:0] acc;
        bit               have;
        for (int i = 0; i < depth; i++) mem[i] = '0;
        idx  = 0;
        acc  = '0;
        have = 1'b0;
        if (init_file != "") begin
            for (int k = 0; k < init_file.len(); k++) begin
                c = int'(init_file[k]);
                if (c >= 48 && c <= 57) begin
                    acc = (acc << 4) | dbits'(c - 48); have = 1'b1;
                end else if (c >= 65 && c <= 70) begin
                    acc = (acc << 4) | dbits'(c - 55); have = 1'b1;
                end else if (c >= 97 && c <= 102) begin
                    acc = (acc << 4) | dbits'(c - 87); have = 1'b1;
                end else if (c == 44) begin
                    if (have && idx < depth) mem[idx] = acc;
                    if (have) idx++;
                    acc = '0; have = 1'b0;
                end else if (!(c == 32 || c == 9 || c == 10 || c == 13)) begin
                    $display("dual_block_ram: bad character %0d in init_file", c);
                    $finish;
                end
            end
            if (have && idx < depth) mem[idx] = acc;
        end
`ifdef BOA_BRAM_PARITY_EN
        for (int i = 0; i < depth; i++) par[i] = lane_parity(mem[i]);
`endif
    end

    logic [dbits-1:0] b_merged, a_final, b_final;
    always_comb begin
        b_merged = lane_merge(b_old, b_wdata, b_we);
        a_final  = lane_merge((b_wr && a_addr == b_addr) ? b_merged : a_old, a_wdata, a_we);
        b_final  = (a_wr && a_addr == b_addr) ? a_final : b_merged;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (b_wr) $display("B[%0d] = %h", b_addr, b_final);
            if (a_wr) $display("A[%0d] = %h", a_addr, a_final);
        end
    end
`endif

endmodule

// File: tb/tb_dual_block_ram.sv
// Bench for dual_block_ram. Two instances share the stimulus:
//   dut0: A read-first, B write-first, no output register
//   dut1: A and B no-change, output register (latency 2)
module tb_dual_block_ram;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
    logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
    logic        collision0, collision1;
    logic [1:0]  perr0, perr1;

    dual_block_ram #(.abits(8), .dbytes(4), .blen(8), .a_mode(0), .b_mode(1), .out_reg(0)) dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
        .collision(collision0), .perr(perr0));

    dual_block_ram #(.abits(8), .dbytes(4), .blen(8), .a_mode(2), .b_mode(2), .out_reg(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .collision(collision1), .perr(perr1));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: word array plus the response each port should be showing.
    logic [31:0] ref_mem [256];
    logic [31:0] e0a_d, e0b_d, r1a_d, r1b_d, e1a_d, e1b_d;
    bit          e0a_v, e0b_v, r1a_v, r1b_v, e1a_v, e1b_v, e_col;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] mask;
        mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // What a port of the given mode shows after an access (or idle cycle).
    task automatic resp(input int mode, input bit en, input logic [3:0] we,
                        input logic [31:0] old, input logic [31:0] wd,
                        input logic [31:0] pd, input bit pv,
                        output logic [31:0] nd, output bit nv);
        nd = pd;
        nv = pv;
        if (!en)                         nv = 1'b0;
        else if (we != 0 && mode == 2) begin end
        else begin
            nv = 1'b1;
            nd = (mode == 1) ? merge(old, wd, we) : old;
        end
    endtask

    task automatic step();
        logic [31:0] oa, ob, n0a, n0b, n1a, n1b;
        bit          v0a, v0b, v1a, v1b;
        oa = ref_mem[a_addr];
        ob = ref_mem[b_addr];
        resp(0, a_en, a_we, oa, a_wdata, e0a_d, e0a_v, n0a, v0a);
        resp(1, b_en, b_we, ob, b_wdata, e0b_d, e0b_v, n0b, v0b);
        resp(2, a_en, a_we, oa, a_wdata, r1a_d, r1a_v, n1a, v1a);
        resp(2, b_en, b_we, ob, b_wdata, r1b_d, r1b_v, n1b, v1b);
        @(posedge clk);
        if (rst) begin
            e0a_d = 0; e0b_d = 0; r1a_d = 0; r1b_d = 0; e1a_d = 0; e1b_d = 0;
            e0a_v = 0; e0b_v = 0; r1a_v = 0; r1b_v = 0; e1a_v = 0; e1b_v = 0;
            e_col = 0;
        end else begin
            e1a_d = r1a_d; e1a_v = r1a_v; e1b_d = r1b_d; e1b_v = r1b_v;
            r1a_d = n1a;   r1a_v = v1a;   r1b_d = n1b;   r1b_v = v1b;
            e0a_d = n0a;   e0a_v = v0a;   e0b_d = n0b;   e0b_v = v0b;
            e_col = a_en && b_en && (a_addr == b_addr) && (a_we != 0 || b_we != 0);
            if (b_en) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_we);
            if (a_en) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_we);
        end
        #1;
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; b_en = 0; b_we = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 128; i++) begin
            a_en = 1; a_we = 4'hF; a_addr = 8'(i);       a_wdata = $urandom;
            b_en = 1; b_we = 4'hF; b_addr = 8'(i + 128); b_wdata = $urandom;
            step();
        end
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] saved;
        saved = ref_mem[5];
        rst = 1; idle();
        a_en = 1; a_we = 4'hF; a_addr = 8'd5; a_wdata = ~saved;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (a_rvalid0 !== 1'b0) $display("FAIL reset_a_rvalid0 got %b want 0", a_rvalid0); else n_pass++;
            n_chk++; if (a_rdata0 !== 32'h0) $display("FAIL reset_a_rdata0 got %h want 0", a_rdata0); else n_pass++;
            n_chk++; if (collision0 !== 1'b0) $display("FAIL reset_collision0 got %b want 0", collision0); else n_pass++;
            n_chk++; if ({a_rvalid1, a_rdata1} !== 33'h0) $display("FAIL reset_dut1_a got %b/%h want 0/0", a_rvalid1, a_rdata1); else n_pass++;
        end
        rst = 0; idle();
        a_en = 1; a_addr = 8'd5;
        step();
        n_chk++; if (a_rdata0 !== saved) $display("FAIL reset_word5 got %h want %h", a_rdata0, saved); else n_pass++;
        n_chk++; if (a_rvalid0 !== 1'b1) $display("FAIL reset_first_read_vld got %b want 1", a_rvalid0); else n_pass++;
        idle();
    endtask

    task automatic test_basic();
        idle(); a_en = 1; a_we = 4'hF; a_addr = 8'd3; a_wdata = 32'hDEADBEEF; step();
        idle(); b_en = 1; b_addr = 8'd3; step();
        n_chk++; if (b_rdata0 !== 32'hDEADBEEF) $display("FAIL basic_b_rdata0 got %h want deadbeef", b_rdata0); else n_pass++;
        n_chk++; if (b_rvalid0 !== 1'b1) $display("FAIL basic_b_rvalid0 got %b want 1", b_rvalid0); else n_pass++;
        n_chk++; if (b_rvalid1 !== 1'b0) $display("FAIL basic_b_rvalid1_early got %b want 0", b_rvalid1); else n_pass++;
        idle(); step();
        n_chk++; if ({b_rvalid1, b_rdata1} !== {1'b1, 32'hDEADBEEF}) $display("FAIL basic_dut1_b got %b/%h want 1/deadbeef", b_rvalid1, b_rdata1); else n_pass++;
        n_chk++; if ({b_rvalid0, b_rdata0} !== {1'b0, 32'hDEADBEEF}) $display("FAIL basic_b_hold got %b/%h want 0/deadbeef", b_rvalid0, b_rdata0); else n_pass++;
    endtask

    task automatic test_modes();
        idle(); b_en = 1; b_we = 4'hF; b_addr = 8'd7; b_wdata = 32'h11223344; step();
        idle(); a_en = 1; a_addr = 8'd3; step();
        idle(); a_en = 1; a_we = 4'b0011; a_addr = 8'd7; a_wdata = 32'hAABBCCDD; step();
        n_chk++; if ({a_rvalid0, a_rdata0} !== {1'b1, 32'h11223344}) $display("FAIL mode_read_first got %b/%h want 1/11223344", a_rvalid0, a_rdata0); else n_pass++;
        idle(); step();
        n_chk++; if ({a_rvalid1, a_rdata1} !== {1'b1, 32'hDEADBEEF}) $display("FAIL mode_no_change got %b/%h want 1/deadbeef", a_rvalid1, a_rdata1); else n_pass++;
        idle(); step();
        n_chk++; if (a_rvalid1 !== 1'b0) $display("FAIL mode_no_change_drop got %b want 0", a_rvalid1); else n_pass++;
        idle(); b_en = 1; b_we = 4'hF; b_addr = 8'd7; b_wdata = 32'h11223344; step();
        idle(); b_en = 1; b_we = 4'b0011; b_addr = 8'd7; b_wdata = 32'hAABBCCDD; step();
        n_chk++; if (b_rdata0 !== 32'h1122CCDD) $display("FAIL mode_write_first got %h want 1122ccdd", b_rdata0); else n_pass++;
        idle(); a_en = 1; a_addr = 8'd7; step();
        n_chk++; if (a_rdata0 !== 32'h1122CCDD) $display("FAIL mode_word_after got %h want 1122ccdd", a_rdata0); else n_pass++;
    endtask

    task automatic test_collision();
        idle(); a_en = 1; a_we = 4'hF; a_addr = 8'd20; a_wdata = 32'h1;
        b_en = 1; b_we = 4'hF; b_addr = 8'd20; b_wdata = 32'h2; step();
        n_chk++; if ({collision0, collision1} !== 2'b11) $display("FAIL coll_ww_flag got %b want 11", {collision0, collision1}); else n_pass++;
        idle(); a_en = 1; a_addr = 8'd20; step();
        n_chk++; if (a_rdata0 !== 32'h1) $display("FAIL coll_ww_stored got %h want 00000001", a_rdata0); else n_pass++;
        n_chk++; if (collision0 !== 1'b0) $display("FAIL coll_clear got %b want 0", collision0); else n_pass++;
        idle(); a_en = 1; a_we = 4'h1; a_addr = 8'd20; a_wdata = 32'hFF;
        b_en = 1; b_we = 4'h2; b_addr = 8'd20; b_wdata = 32'hEE00; step();
        n_chk++; if (collision0 !== 1'b1) $display("FAIL coll_disjoint_flag got %b want 1", collision0); else n_pass++;
        idle(); a_en = 1; a_addr = 8'd20; step();
        n_chk++; if (a_rdata0 !== 32'h0000EEFF) $display("FAIL coll_disjoint_stored got %h want 0000eeff", a_rdata0); else n_pass++;
        idle(); a_en = 1; a_addr = 8'd20; b_en = 1; b_we = 4'hF; b_addr = 8'd20; b_wdata = 32'h12345678; step();
        n_chk++; if (a_rdata0 !== 32'h0000EEFF) $display("FAIL coll_read_old got %h want 0000eeff", a_rdata0); else n_pass++;
        n_chk++; if (collision0 !== 1'b1) $display("FAIL coll_rw_flag got %b want 1", collision0); else n_pass++;
        n_chk++; if (b_rdata0 !== 32'h12345678) $display("FAIL coll_b_wf got %h want 12345678", b_rdata0); else n_pass++;
        idle(); a_en = 1; a_addr = 8'd20; b_en = 1; b_addr = 8'd20; step();
        n_chk++; if (collision0 !== 1'b0) $display("FAIL coll_rr_flag got %b want 0", collision0); else n_pass++;
        idle(); a_en = 1; a_we = 4'hF; a_addr = 8'd21; a_wdata = 32'h5; b_en = 1; b_addr = 8'd22; step();
        n_chk++; if (collision0 !== 1'b0) $display("FAIL coll_diff_addr got %b want 0", collision0); else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 256; i++) begin
            idle(); a_en = 1; a_addr = 8'(i);
            step();
            n_chk++; if ({a_rvalid0, a_rdata0} !== {1'b1, ref_mem[i % 256]})
                $display("FAIL b2b_dut0 i=%0d got %b/%h want 1/%h", i, a_rvalid0, a_rdata0, ref_mem[i % 256]);
            else n_pass++;
            if (i > 0) begin
                n_chk++; if ({a_rvalid1, a_rdata1} !== {1'b1, ref_mem[(i - 1) % 256]})
                    $display("FAIL b2b_dut1 i=%0d got %b/%h want 1/%h", i, a_rvalid1, a_rdata1, ref_mem[(i - 1) % 256]);
                else n_pass++;
            end
        end
        idle(); step();
        n_chk++; if (a_rvalid0 !== 1'b0) $display("FAIL b2b_end_vld got %b want 0", a_rvalid0); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_en = 1'($urandom_range(0, 1)); a_addr = 8'($urandom_range(0, 7)); a_wdata = $urandom;
            a_we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            b_en = 1'($urandom_range(0, 1)); b_addr = 8'($urandom_range(0, 7)); b_wdata = $urandom;
            b_we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            step();
            n_chk++; if ({a_rvalid0, a_rdata0, b_rvalid0, b_rdata0, collision0} !== {e0a_v, e0a_d, e0b_v, e0b_d, e_col})
                $display("FAIL rand_dut0 i=%0d got %b/%h %b/%h c%b want %b/%h %b/%h c%b", i, a_rvalid0, a_rdata0,
                         b_rvalid0, b_rdata0, collision0, e0a_v, e0a_d, e0b_v, e0b_d, e_col);
            else n_pass++;
            n_chk++; if ({a_rvalid1, a_rdata1, b_rvalid1, b_rdata1, collision1} !== {e1a_v, e1a_d, e1b_v, e1b_d, e_col})
                $display("FAIL rand_dut1 i=%0d got %b/%h %b/%h c%b want %b/%h %b/%h c%b", i, a_rvalid1, a_rdata1,
                         b_rvalid1, b_rdata1, collision1, e1a_v, e1a_d, e1b_v, e1b_d, e_col);
            else n_pass++;
            n_chk++; if ({perr0, perr1} !== 4'b0) $display("FAIL rand_perr i=%0d got %b/%b want 00/00", i, perr0, perr1); else n_pass++;
        end
        idle();
    endtask

    task automatic test_parity();
`ifdef BOA_BRAM_PARITY_EN
        idle(); a_en = 1; a_addr = 8'd9; step();
        n_chk++; if (perr0 !== 2'b00) $display("FAIL parity_clean got %b want 00", perr0); else n_pass++;
        dut0.mem[9] = dut0.mem[9] ^ 32'h1;
        idle(); a_en = 1; a_addr = 8'd9; step();
        n_chk++; if ({perr0[0], a_rvalid0} !== 2'b11) $display("FAIL parity_flag got perr=%b vld=%b want 1/1", perr0[0], a_rvalid0); else n_pass++;
        n_chk++; if (a_rdata0 !== (ref_mem[9] ^ 32'h1)) $display("FAIL parity_data got %h want %h", a_rdata0, ref_mem[9] ^ 32'h1); else n_pass++;
        idle(); step();
        n_chk++; if (perr0 !== 2'b00) $display("FAIL parity_clear got %b want 00", perr0); else n_pass++;
`else
        idle(); a_en = 1; a_addr = 8'd9; b_en = 1; b_addr = 8'd10; step();
        n_chk++; if (perr0 !== 2'b00) $display("FAIL parity_off_dut0 got %b want 00", perr0); else n_pass++;
        idle(); step();
        n_chk++; if (perr1 !== 2'b00) $display("FAIL parity_off_dut1 got %b want 00", perr1); else n_pass++;
`endif
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rst = 1; idle(); a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        step(); step();
        rst = 0;
        fill();
        test_reset();
        test_basic();
        test_modes();
        test_collision();
        test_back_to_back();
        test_random();
        test_parity();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
